// File: rtl/ocimem_access_arbiter.sv
// rtl/ocimem_access_arbiter.sv - CPU / JTAG arbiter for the single-port on-chip debug RAM
module ocimem_access_arbiter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_address,
    input  logic [31:0]   cpu_writedata,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          jtag_busy,
    output logic          jtag_overrun,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WR_ACK,
        CPU_RD_WAIT,
        CPU_RD_ACK,
        JTAG_RD_WAIT,
        JTAG_DONE
    } state_t;

    state_t        state, state_next;

    logic          last_grant_jtag;
    logic [AW-1:0] jtag_addr;
    logic          cmd_rw;
    logic [31:0]   cmd_wdata;
    logic [AW-1:0] cmd_addr;

    logic          cpu_req;
    logic          grant_cpu;
    logic          grant_jtag;
    logic [AW-1:0] strobe_addr;

    // jdo bits outside the address and write-data fields carry nothing for this block
    logic          unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign cpu_req     = cpu_read | cpu_write;
    // CPU wins when alone, or on a tie when JTAG had the previous grant
    assign grant_cpu   = cpu_req & (~jtag_busy | last_grant_jtag);
    assign grant_jtag  = jtag_busy & ~grant_cpu;
    // a same-cycle address load is seen by the access strobe
    assign strobe_addr = take_action_ocimem_a ? jdo[16+AW:17] : jtag_addr;

    // JTAG front end: address register, command latch, busy and overrun flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_addr    <= '0;
            cmd_rw       <= 1'b0;
            cmd_wdata    <= '0;
            cmd_addr     <= '0;
            jtag_busy    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            if (take_action_ocimem_a) begin
                jtag_addr <= jdo[16+AW:17];
            end else if (state == JTAG_DONE) begin
                jtag_addr <= AW'(jtag_addr + 1'b1);
            end

            if (take_action_ocimem_b && !jtag_busy) begin
                cmd_rw    <= jdo[35];
                cmd_wdata <= jdo[34:3];
                cmd_addr  <= strobe_addr;
                jtag_busy <= 1'b1;
            end else if (state == JTAG_DONE) begin
                jtag_busy <= 1'b0;
            end

            if (take_action_ocimem_b && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_overrun <= 1'b0;
            end
        end
    end

    // FSM state, round-robin history and read-data capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_grant_jtag <= 1'b1;
            cpu_readdata    <= '0;
            MonDReg         <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (grant_cpu) begin
                    last_grant_jtag <= 1'b0;
                end else if (grant_jtag) begin
                    last_grant_jtag <= 1'b1;
                end
            end
            if (state == CPU_RD_WAIT) begin
                cpu_readdata <= ram_rdata;
            end
            if (state == JTAG_RD_WAIT) begin
                MonDReg <= ram_rdata;
            end
        end
    end

    // Next-state and RAM/handshake outputs; RAM strobes are held off while reset is high
    always_comb begin
        state_next      = state;
        ram_addr        = '0;
        ram_wdata       = '0;
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        cpu_waitrequest = 1'b1;
        monitor_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && grant_cpu) begin
                    ram_addr = cpu_address;
                    if (cpu_write) begin
                        ram_we     = 1'b1;
                        ram_wdata  = cpu_writedata;
                        state_next = CPU_WR_ACK;
                    end else begin
                        ram_re     = 1'b1;
                        state_next = CPU_RD_WAIT;
                    end
                end else if (!reset && grant_jtag) begin
                    ram_addr = cmd_addr;
                    if (cmd_rw) begin
                        ram_we     = 1'b1;
                        ram_wdata  = cmd_wdata;
                        state_next = JTAG_DONE;
                    end else begin
                        ram_re     = 1'b1;
                        state_next = JTAG_RD_WAIT;
                    end
                end
            end
            CPU_WR_ACK: begin
                cpu_waitrequest = 1'b0;
                state_next      = IDLE;
            end
            CPU_RD_WAIT: begin
                state_next = CPU_RD_ACK;
            end
            CPU_RD_ACK: begin
                cpu_waitrequest = 1'b0;
                state_next      = IDLE;
            end
            JTAG_RD_WAIT: begin
                state_next = JTAG_DONE;
            end
            JTAG_DONE: begin
                monitor_ready = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// tb/tb_ocimem_access_arbiter.sv - directed bench for ocimem_access_arbiter
module tb_ocimem_access_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [37:0]   jdo = '0;
    logic          take_action_ocimem_a = 1'b0;
    logic          take_action_ocimem_b = 1'b0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [31:0]   cpu_writedata = '0;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          jtag_busy;
    logic          jtag_overrun;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata = '0;
    logic [31:0]   mem [256];

    int errors = 0;
    int checks = 0;

    ocimem_access_arbiter #(.AW(AW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_action_ocimem_a),
        .take_action_ocimem_b (take_action_ocimem_b),
        .cpu_read             (cpu_read),
        .cpu_write            (cpu_write),
        .cpu_address          (cpu_address),
        .cpu_writedata        (cpu_writedata),
        .cpu_readdata         (cpu_readdata),
        .cpu_waitrequest      (cpu_waitrequest),
        .MonDReg              (MonDReg),
        .monitor_ready        (monitor_ready),
        .jtag_busy            (jtag_busy),
        .jtag_overrun         (jtag_overrun),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_we               (ram_we),
        .ram_re               (ram_re),
        .ram_rdata            (ram_rdata)
    );

    always #5 clk = ~clk;

    // single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [AW-1:0] addr);
        cyc();
        jdo = '0;
        jdo[16+AW:17] = addr;
        take_action_ocimem_a = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_access(input bit do_a, input logic [AW-1:0] addr, input bit rw,
                               input logic [31:0] data, input int exp_lat, input bit extra_b);
        int n;
        bit seen;
        cyc();
        jdo = {2'b00, rw, data, 3'b000};
        if (do_a) jdo[16+AW:17] = addr;
        take_action_ocimem_a = do_a;
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = extra_b;
        #1;
        check("jtag_busy_set", jtag_busy, 1);
        check("jtag_grant_en", rw ? ram_we : ram_re, 1);
        check("jtag_ram_addr", ram_addr, addr);
        if (rw) check("jtag_ram_wdata", ram_wdata, data);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 10) begin
            cyc();
            take_action_ocimem_b = 1'b0;
            #1;
            n++;
            seen = monitor_ready;
        end
        check("jtag_latency", n, exp_lat);
        if (!rw) check("mon_dreg", MonDReg, data);
        cyc();
        #1;
        check("jtag_busy_clear", jtag_busy, 0);
        check("monitor_ready_pulse", monitor_ready, 0);
    endtask

    task automatic cpu_access(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                              input int exp_lat);
        int n;
        cyc();
        cpu_write = wr;
        cpu_read = !wr;
        cpu_address = addr;
        cpu_writedata = data;
        #1;
        check("cpu_grant_en", wr ? ram_we : ram_re, 1);
        check("cpu_ram_addr", ram_addr, addr);
        if (wr) check("cpu_ram_wdata", ram_wdata, data);
        n = 0;
        while (cpu_waitrequest && n < 10) begin
            cyc();
            #1;
            n++;
        end
        check("cpu_latency", n, exp_lat);
        if (!wr) check("cpu_readdata", cpu_readdata, data);
        cyc();
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // reset state
        cyc(); cyc(); cyc();
        check("rst_waitrequest", cpu_waitrequest, 1);
        check("rst_readdata", cpu_readdata, 0);
        check("rst_mondreg", MonDReg, 0);
        check("rst_outputs", {monitor_ready, jtag_busy, jtag_overrun, ram_we, ram_re}, 0);
        reset = 1'b0;

        // JTAG write at 0x10, then auto-incremented write at 0x11, then read back 0x10
        set_addr(8'h10);
        jtag_access(1'b0, 8'h10, 1'b1, 32'hDEADBEEF, 2, 1'b0);
        jtag_access(1'b0, 8'h11, 1'b1, 32'hCAFEF00D, 2, 1'b0);
        jtag_access(1'b1, 8'h10, 1'b0, 32'hDEADBEEF, 3, 1'b0);
        check("no_overrun_yet", jtag_overrun, 0);

        // CPU write then read
        cpu_access(1'b1, 8'h05, 32'h12345678, 1);
        cpu_access(1'b0, 8'h05, 32'h12345678, 2);

        // address wrap with a dropped second strobe
        set_addr(8'hFF);
        jtag_access(1'b0, 8'hFF, 1'b1, 32'h11111111, 2, 1'b1);
        check("overrun_set", jtag_overrun, 1);
        n = 0;
        repeat (3) begin
            cyc();
            #1;
            if (monitor_ready || jtag_busy) n++;
        end
        check("dropped_strobe_quiet", n, 0);
        jtag_access(1'b0, 8'h00, 1'b1, 32'h22222222, 2, 1'b0);
        check("overrun_sticky", jtag_overrun, 1);
        set_addr(8'h00);
        #1;
        check("overrun_cleared", jtag_overrun, 0);

        // reset in CPU_RD_WAIT with a JTAG command latched
        cyc();
        cpu_read = 1'b1;
        cpu_address = 8'h05;
        jdo = {2'b00, 1'b1, 32'hA5A5A5A5, 3'b000};
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
        #1;
        check("pre_reset_busy", jtag_busy, 1);
        reset = 1'b1;
        #1;
        check("async_rst_waitrequest", cpu_waitrequest, 1);
        check("async_rst_readdata", cpu_readdata, 0);
        check("async_rst_mondreg", MonDReg, 0);
        check("async_rst_outputs", {monitor_ready, jtag_busy, jtag_overrun, ram_we, ram_re}, 0);
        cpu_read = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            cyc();
            #1;
            if (monitor_ready || jtag_busy) n++;
        end
        check("post_reset_quiet", n, 0);

        // contention after reset: CPU first, then alternating
        cyc();
        jdo = '0;
        take_action_ocimem_b = 1'b1;
        cyc();
        take_action_ocimem_b = 1'b0;
        cpu_read = 1'b1;
        cpu_address = 8'h05;
        #1;
        check("tie1_cpu_first", {ram_re, ram_addr}, {1'b1, 8'h05});
        cyc(); cyc(); #1;
        check("tie1_cpu_ack", cpu_waitrequest, 0);
        check("tie1_cpu_data", cpu_readdata, 32'h12345678);
        cyc(); #1;
        check("tie2_jtag_next", {ram_re, ram_addr}, {1'b1, 8'h00});
        check("tie2_cpu_waits", cpu_waitrequest, 1);
        cyc(); cyc(); #1;
        check("tie2_jtag_done", monitor_ready, 1);
        check("tie2_mondreg", MonDReg, 32'h22222222);
        cyc();
        take_action_ocimem_b = 1'b1;
        #1;
        check("tie3_cpu_grant", {ram_re, ram_addr}, {1'b1, 8'h05});
        cyc();
        take_action_ocimem_b = 1'b0;
        cyc(); #1;
        check("tie3_cpu_ack", cpu_waitrequest, 0);
        cyc(); #1;
        check("tie4_jtag_incr", {ram_re, ram_addr}, {1'b1, 8'h01});
        cyc(); cyc(); cyc(); #1;
        check("tie5_cpu_grant", {ram_re, ram_addr}, {1'b1, 8'h05});
        cyc(); cyc(); #1;
        check("tie5_cpu_ack", cpu_waitrequest, 0);
        cyc();
        cpu_read = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
